// File: rtl/reset_sequencer_pkg.sv
// Shared types, limits and parameter-legality helpers for the reset sequencer.
// Imported by reset_sequencer and reset_sync_chain.
`ifndef BSV_ASSIGNMENT_DELAY
`define BSV_ASSIGNMENT_DELAY
`endif

package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    localparam int MIN_SYNC_DEPTH = 2;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The counter must be able to reach HOLD-1 and GAP-1 without wrapping.
    function automatic bit params_ok(input int num_stages, input int hold,
                                     input int gap, input int sync_depth,
                                     input int cw);
        return (num_stages >= 1) && (hold >= 1) && (gap >= 1) &&
               (sync_depth >= MIN_SYNC_DEPTH) && (cw >= 1) && (cw <= 30) &&
               ((2 ** cw) > max2(hold, gap));
    endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// DEPTH-flop synchronizer for an asynchronous active-low reset request.
// Reset forces every flop to 0, so a block reset always reads as a pending request.
module reset_sync_chain
    import reset_sequencer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic D_IN,
    output logic D_OUT
);

    logic [DEPTH-1:0] r_sync;

    generate
        if (DEPTH < MIN_SYNC_DEPTH) begin : g_bad_depth
            $error("reset_sync_chain: DEPTH must be >= %0d", MIN_SYNC_DEPTH);
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so each flop samples its predecessor's old value.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[DEPTH-2:0], D_IN};
        end
    end

    assign D_OUT = r_sync[DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// Sequenced reset generator: all outputs assert together, then release one by one
// in index order after a minimum hold; a software request re-runs the whole sequence.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int HOLD       = 8,
    parameter int GAP        = 2,
    parameter int SYNC_DEPTH = 2,
    parameter int CW         = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IN_RST,
    input  logic                  EN_swReset,
    output logic                  RDY_swReset,
    output logic [NUM_STAGES-1:0] OUT_RST,
    output logic                  READY
);

    localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

    generate
        if (!params_ok(NUM_STAGES, HOLD, GAP, SYNC_DEPTH, CW)) begin : g_bad_params
            $error("reset_sequencer: illegal parameter set");
        end
    endgenerate

    state_e                r_state;
    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    logic [NUM_STAGES-1:0] r_out_rst;
    logic                  r_ready;
    logic                  w_in_ok;

    reset_sync_chain #(
        .DEPTH (SYNC_DEPTH)
    ) u_in_sync (
        .CLK   (CLK),
        .RST   (RST),
        .D_IN  (IN_RST),
        .D_OUT (w_in_ok)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state   <= ST_ASSERT;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_out_rst <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    r_out_rst <= '0;
                    r_ready   <= 1'b0;
                    if (!w_in_ok) begin
                        r_cnt <= '0;
                    end else if (r_cnt == HOLD_LAST) begin
                        r_out_rst <= NUM_STAGES'(1);
                        r_cnt     <= '0;
                        r_idx     <= IW'(1);
                        r_state   <= (NUM_STAGES > 1) ? ST_RELEASE : ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                ST_RELEASE: begin
                    if (!w_in_ok) begin
                        r_out_rst <= '0;
                        r_cnt     <= '0;
                        r_state   <= ST_ASSERT;
                    end else if (r_cnt == GAP_LAST) begin
                        // Bits release strictly in order, so shifting in a 1 releases bit r_idx.
                        r_out_rst <= (r_out_rst << 1) | NUM_STAGES'(1);
                        r_idx     <= r_idx + IW'(1);
                        r_cnt     <= '0;
                        if (r_idx == IDX_LAST) begin
                            r_state <= ST_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                ST_DONE: begin
                    if (!w_in_ok || EN_swReset) begin
                        r_out_rst <= '0;
                        r_ready   <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= ST_ASSERT;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end

                default: begin
                    r_out_rst <= '0;
                    r_ready   <= 1'b0;
                    r_cnt     <= '0;
                    r_idx     <= '0;
                    r_state   <= ST_ASSERT;
                end
            endcase
        end
    end

    assign OUT_RST     = r_out_rst;
    assign READY       = r_ready;
    assign RDY_swReset = (r_state == ST_DONE);

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Consumes the combined reset produced by the two-input reset combiner and emits NUM_STAGES active-low reset outputs.
- All outputs assert together. They release one at a time, in index order, after a guaranteed minimum hold time.
- Downstream domains therefore come out of reset in a fixed order.
- A software-initiated reset method (EN_/RDY_ pair) lets a running design re-enter the full sequence.

Parameters:
- NUM_STAGES, 4: number of sequenced reset outputs; must be >= 1.
- HOLD, 8: minimum cycles all outputs stay asserted after the request clears; must be >= 1.
- GAP, 2: cycles between successive stage releases; must be >= 1.
- SYNC_DEPTH, 2: flops in the IN_RST synchronizer chain; must be >= 2.
- CW, 8: counter width; must satisfy 2**CW > max(HOLD, GAP).

Ports:
- CLK  input  1  block clock.
- RST  input  1  block reset. One clock; reset is synchronous and active-low (0 = reset), fixed regardless of BSV_POSITIVE_RESET.
- IN_RST  input  1  combined reset request, active-low, may be asynchronous to CLK.
- EN_swReset  input  1  software reset request; only honoured while RDY_swReset=1.
- RDY_swReset  output  1  high only in DONE.
- OUT_RST  output  NUM_STAGES  sequenced resets, active-low, registered; bit 0 releases first.
- READY  output  1  high when all stages are released.

Behaviour:
- Edge numbering: edge 1 is the first rising CLK edge at which RST is sampled 1.
- RST=0 at an edge:
  - state := ASSERT, counter := 0.
  - All sync flops := 0 (asserted).
  - OUT_RST := all 0, READY := 0.
  - RDY_swReset is 0.
- Synchronizer: IN_RST passes through SYNC_DEPTH flops to give in_ok. The FSM uses only in_ok.
- State ASSERT:
  - OUT_RST all 0, READY 0.
  - If in_ok=0: counter := 0.
  - Else if counter == HOLD-1: OUT_RST[0] := 1, counter := 0, stage index := 1.
    - Go to RELEASE if NUM_STAGES > 1.
    - Otherwise go to DONE, with READY := 1 at the next edge.
  - Else: counter += 1.
- State RELEASE:
  - If in_ok=0: go to ASSERT, OUT_RST := all 0, counter := 0.
  - Else if counter == GAP-1: OUT_RST[index] := 1, index += 1, counter := 0.
    - If the bit just released was NUM_STAGES-1, go to DONE.
  - Else: counter += 1.
- State DONE:
  - READY := 1 on the entry edge + 1 (one cycle after the last bit releases). RDY_swReset = 1.
  - in_ok=0 or EN_swReset=1: go to ASSERT, OUT_RST := all 0, READY := 0, counter := 0.
  - If both occur on the same edge, the result is identical.
- Released bits never re-assert individually. Any return to ASSERT drops all bits on the same edge.
- Timing with defaults and IN_RST held high from reset:
  - OUT_RST[i] rises after edge SYNC_DEPTH + HOLD + i*GAP, i.e. edges 10, 12, 14, 16.
  - READY rises after edge 17.
- Assertion latency: IN_RST first sampled low at edge k gives OUT_RST all 0 after edge k+SYNC_DEPTH.
- Software reset: EN_swReset accepted at edge e gives OUT_RST all 0 after edge e. OUT_RST[0] re-releases after edge e+HOLD.
- IN_RST glitch shorter than one cycle: may or may not be captured. If captured, it restarts HOLD in full.
- RST=0 mid-sequence: immediate return to the reset state above at that edge.
- Illegal 2-bit state encoding: recover to ASSERT.

Decomposition:
- Shared include (reset_seq_defs.vh):
  - State encodings ASSERT=2'd0, RELEASE=2'd1, DONE=2'd2.
  - Parameter-legality check macros.
  - The BSV_ASSIGNMENT_DELAY default guard.
- One sub-module, reset_sync_chain (parameter DEPTH; ports CLK, RST, D_IN, D_OUT).
  - Synchronous active-low reset to 0.
  - Instantiated once for IN_RST.
- FSM, counter, index and output register stay in reset_sequencer.

Test Plan:
1. Power-up: RST=0 for 3 edges, then 1; IN_RST=1 constant -> OUT_RST 0000 until edge 10, then 0001, 0011 after edge 12, 0111 after edge 14, 1111 after edge 16; READY=1 after edge 17.
2. Short request mid-RELEASE: IN_RST low at edge 13 only -> OUT_RST 0000 after edge 15; with IN_RST high again, OUT_RST[0] rises after edge 15+SYNC_DEPTH+HOLD-1 ... recheck against the counter rule: in_ok returns 1 after edge 15, so bit0 rises after edge 23.
3. Software reset in DONE: EN_swReset=1 at edge 20 -> RDY_swReset and READY 0 and OUT_RST 0000 after edge 20; OUT_RST[0]=1 after edge 28; READY=1 after edge 35.
4. EN_swReset=1 while RDY_swReset=0 (edges 5-15) -> ignored; release timing identical to scenario 1.
5. RST=0 asserted at edge 13 for 1 edge -> all outputs 0 after edge 13; sequence restarts with edge 14 as the new edge 1; bit0 rises after edge 23.
6. Corner parameters NUM_STAGES=1, HOLD=1, GAP=1 -> OUT_RST[0] rises after edge SYNC_DEPTH+1=3; READY=1 after edge 4; in_ok drop re-asserts within SYNC_DEPTH edges.
